// File: rtl/udp_arb_pkg.sv
// udp_arb_pkg: shared state encoding and field widths for the UDP TX arbiter.
package udp_arb_pkg;

    localparam int DATA_W = 32;
    localparam int KEEP_W = 4;
    localparam int LEN_W  = 16;
    localparam int IP_W   = 32;
    localparam int PORT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/udp_rr_pick.sv
// udp_rr_pick: combinational round-robin picker. Searches the request vector
// starting one position after last_owner, wrapping modulo NUM_REQ, and
// returns the first asserted requester as a one-hot vector plus its index.
module udp_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    // Walk the requesters in rotated priority order; the first hit wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_owner) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any        = 1'b1;
                pick[cand] = 1'b1;
                idx        = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares send_top's single UDP application input among
// NUM_REQ packet sources. Whole packets are granted round-robin; the granted
// packet's length, destination IP and port are latched at grant time, and
// GAP_CYCLES idle cycles are forced after each packet's last beat.
// Optional build macro ARB_PKT_CNT_EN adds per-requester 16-bit wrapping
// sent-packet counters; without it pkt_cnt is tied to zero.
module udp_tx_arbiter
    import udp_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 64
) (
    input  logic                      clk_32,
    input  logic                      reset_32,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [32*NUM_REQ-1:0]     req_data,
    input  logic [4*NUM_REQ-1:0]      req_keep,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [16*NUM_REQ-1:0]     req_length,
    input  logic [32*NUM_REQ-1:0]     req_dest_ip,
    input  logic [16*NUM_REQ-1:0]     req_dest_port,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      udp_from_app_valid,
    output logic [31:0]               udp_from_app_data,
    output logic [3:0]                udp_from_app_keep,
    output logic                      udp_from_app_last,
    input  logic                      udp_to_app_ready,
    output logic [15:0]               data_from_app_length,
    output logic [31:0]               dest_ip_addr,
    output logic [15:0]               dest_port,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [16*NUM_REQ-1:0]     pkt_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = 16;

    // Per-requester views of the flattened input buses.
    logic [DATA_W-1:0] data_a [NUM_REQ];
    logic [KEEP_W-1:0] keep_a [NUM_REQ];
    logic [LEN_W-1:0]  len_a  [NUM_REQ];
    logic [IP_W-1:0]   ip_a   [NUM_REQ];
    logic [PORT_W-1:0] port_a [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : gen_unpack
            assign data_a[gi] = req_data[DATA_W*gi +: DATA_W];
            assign keep_a[gi] = req_keep[KEEP_W*gi +: KEEP_W];
            assign len_a[gi]  = req_length[LEN_W*gi +: LEN_W];
            assign ip_a[gi]   = req_dest_ip[IP_W*gi +: IP_W];
            assign port_a[gi] = req_dest_port[PORT_W*gi +: PORT_W];
        end
    endgenerate

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IP_W-1:0]    ip_q, ip_d;
    logic [PORT_W-1:0]  port_q, port_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               beat_xfer;
    logic               last_xfer;

    udp_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_owner (owner_q),
        .pick       (pick_oh),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    // Output path: the owner's beat passes straight through while in XFER;
    // everything is forced quiet otherwise. grant_q is only non-zero in XFER.
    always_comb begin
        udp_from_app_valid = 1'b0;
        udp_from_app_data  = '0;
        udp_from_app_keep  = '0;
        udp_from_app_last  = 1'b0;
        if (state_q == XFER) begin
            udp_from_app_valid = req_valid[owner_q];
            udp_from_app_data  = data_a[owner_q];
            udp_from_app_keep  = keep_a[owner_q];
            udp_from_app_last  = req_last[owner_q];
        end
        req_ready = grant_q & {NUM_REQ{udp_to_app_ready}};
        beat_xfer = udp_from_app_valid & udp_to_app_ready;
        last_xfer = beat_xfer & udp_from_app_last;
    end

    // Next-state logic: grant in IDLE, release on the last beat, count out the gap.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        len_d   = len_q;
        ip_d    = ip_q;
        port_d  = port_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    len_d   = len_a[pick_idx];
                    ip_d    = ip_a[pick_idx];
                    port_d  = port_a[pick_idx];
                    state_d = XFER;
                end
            end
            XFER: begin
                if (last_xfer) begin
                    grant_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbitration state; last owner starts at NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk_32 or posedge reset_32) begin
        if (reset_32) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= IDX_W'(NUM_REQ - 1);
            len_q   <= '0;
            ip_q    <= '0;
            port_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            ip_q    <= ip_d;
            port_q  <= port_d;
            gap_q   <= gap_d;
        end
    end

    assign grant                = grant_q;
    assign busy                 = (state_q != IDLE);
    assign data_from_app_length = len_q;
    assign dest_ip_addr         = ip_q;
    assign dest_port            = port_q;

`ifdef ARB_PKT_CNT_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : gen_cnt
            logic [LEN_W-1:0] cnt_q, cnt_d;

            // Count completed packets from this requester, wrapping at 16 bits.
            always_comb begin
                cnt_d = cnt_q;
                if (last_xfer && (owner_q == IDX_W'(gi))) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Counter register, cleared by reset.
            always_ff @(posedge clk_32 or posedge reset_32) begin
                if (reset_32) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign pkt_cnt[LEN_W*gi +: LEN_W] = cnt_q;
        end
    endgenerate
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed scenario tests for udp_tx_arbiter (NUM_REQ=4,
// GAP_CYCLES=64). Each requester is a simple packet source whose beat word
// encodes {requester, packet number, beat number}.
module tb_udp_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 64;

    logic              clk_32 = 1'b0;
    logic              reset_32 = 1'b1;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_data;
    logic [4*N-1:0]    req_keep;
    logic [N-1:0]      req_last;
    logic [16*N-1:0]   req_length;
    logic [32*N-1:0]   req_dest_ip;
    logic [16*N-1:0]   req_dest_port;
    logic [N-1:0]      req_ready;
    logic              udp_from_app_valid;
    logic [31:0]       udp_from_app_data;
    logic [3:0]        udp_from_app_keep;
    logic              udp_from_app_last;
    logic              udp_to_app_ready;
    logic [15:0]       data_from_app_length;
    logic [31:0]       dest_ip_addr;
    logic [15:0]       dest_port;
    logic [N-1:0]      grant;
    logic              busy;
    logic [16*N-1:0]   pkt_cnt;

    always #5 clk_32 = ~clk_32;

    udp_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP)) dut (
        .clk_32               (clk_32),
        .reset_32             (reset_32),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_keep             (req_keep),
        .req_last             (req_last),
        .req_length           (req_length),
        .req_dest_ip          (req_dest_ip),
        .req_dest_port        (req_dest_port),
        .req_ready            (req_ready),
        .udp_from_app_valid   (udp_from_app_valid),
        .udp_from_app_data    (udp_from_app_data),
        .udp_from_app_keep    (udp_from_app_keep),
        .udp_from_app_last    (udp_from_app_last),
        .udp_to_app_ready     (udp_to_app_ready),
        .data_from_app_length (data_from_app_length),
        .dest_ip_addr         (dest_ip_addr),
        .dest_port            (dest_port),
        .grant                (grant),
        .busy                 (busy),
        .pkt_cnt              (pkt_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int src_pk[N];
    int src_nb[N];
    int src_bt[N];
    int src_sent[N];
    bit src_hold[N];

    logic [31:0] log_data[$];
    logic        log_last[$];

    function automatic logic [31:0] beat_word(int i, int p, int b);
        return {4'(i), 12'(p), 16'(b)};
    endfunction

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (src_pk[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]              = (src_pk[i] > 0) && !src_hold[i];
            req_data[32*i +: 32]      = beat_word(i, src_sent[i], src_bt[i]);
            req_last[i]               = (src_bt[i] == src_nb[i] - 1);
            req_keep[4*i +: 4]        = 4'hF;
            req_length[16*i +: 16]    = 16'(src_nb[i] * 4);
            req_dest_ip[32*i +: 32]   = 32'hC0A80002 + 32'(i);
            req_dest_port[16*i +: 16] = 16'(5000 + i);
        end
    endtask

    // One clock: log the beat about to transfer, clock it, advance sources.
    task automatic tick();
        logic [N-1:0] fire;
        fire = req_valid & req_ready;
        if (udp_from_app_valid && udp_to_app_ready) begin
            log_data.push_back(udp_from_app_data);
            log_last.push_back(udp_from_app_last);
            $display("beat t=%0t grant=%b data=%08h keep=%h last=%b", $time, grant,
                     udp_from_app_data, udp_from_app_keep, udp_from_app_last);
        end
        @(posedge clk_32);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                if (src_bt[i] == src_nb[i] - 1) begin
                    src_bt[i] = 0;
                    src_pk[i]--;
                    src_sent[i]++;
                end else begin
                    src_bt[i]++;
                end
            end
        end
        drive_inputs();
        #1;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_pk[i] = 0; src_nb[i] = 1; src_bt[i] = 0; src_sent[i] = 0; src_hold[i] = 1'b0;
        end
        log_data.delete();
        log_last.delete();
        udp_to_app_ready = 1'b1;
        drive_inputs();
    endtask

    task automatic do_reset();
        reset_32 = 1'b1;
        clear_sources();
        repeat (2) @(posedge clk_32);
        #1;
        reset_32 = 1'b0;
        #1;
    endtask

    task automatic run_until_idle(input int maxc, output bit ok);
        int c = 0;
        while (c < maxc && (pending() || busy)) begin
            tick();
            c++;
        end
        ok = (c < maxc);
    endtask

    task automatic test_reset();
        reset_32 = 1'b1;
        clear_sources();
        src_pk[1] = 1;
        drive_inputs();
        repeat (2) @(posedge clk_32);
        #1;
        n_checks++;
        if ({grant, busy, udp_from_app_valid, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got grant=%b busy=%b valid=%b ready=%b exp all 0",
                     grant, busy, udp_from_app_valid, req_ready);
        end
        n_checks++;
        if ({data_from_app_length, dest_ip_addr, dest_port} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_latch got len=%h ip=%h port=%h exp 0",
                     data_from_app_length, dest_ip_addr, dest_port);
        end
        n_checks++;
        if (pkt_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_pkt_cnt got=%h exp=0", pkt_cnt);
        end
        reset_32 = 1'b0;
        #1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        int  g;
        bit  bad;
        bit  ok;
        do_reset();
        src_nb[0] = 4; src_pk[0] = 1;
        drive_inputs();
        #1;
        n_checks++;
        if (grant !== 4'b0000 || udp_from_app_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_idle got grant=%b valid=%b exp 0000/0", grant, udp_from_app_valid);
        end
        tick();
        n_checks++;
        if (grant !== 4'b0001 || busy !== 1'b1 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL t1_grant got grant=%b busy=%b ready=%b exp 0001/1/0001", grant, busy, req_ready);
        end
        n_checks++;
        if (dest_ip_addr !== 32'hC0A80002 || data_from_app_length !== 16'd16 || dest_port !== 16'd5000) begin
            n_fail++;
            $display("FAIL t1_latch got ip=%h len=%0d port=%0d exp c0a80002/16/5000",
                     dest_ip_addr, data_from_app_length, dest_port);
        end
        g = 0;
        while (log_data.size() < 4 && g < 20) begin tick(); g++; end
        n_checks++;
        if (log_data.size() != 4) begin
            n_fail++;
            $display("FAIL t1_beat_count got=%0d exp=4", log_data.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                n_checks++;
                if (log_data[b] !== beat_word(0, 0, b) || log_last[b] !== (b == 3)) begin
                    n_fail++;
                    $display("FAIL t1_beat%0d got=%08h/%b exp=%08h/%b", b, log_data[b], log_last[b],
                             beat_word(0, 0, b), (b == 3));
                end
            end
        end
        g = 0; bad = 1'b0;
        while (busy && g < 200) begin
            if (grant !== '0 || req_ready !== '0 || udp_from_app_valid !== 1'b0) bad = 1'b1;
            g++;
            tick();
        end
        n_checks++;
        if (g != GAP || bad) begin
            n_fail++;
            $display("FAIL t1_gap got cycles=%0d quiet_err=%b exp cycles=%0d quiet_err=0", g, bad, GAP);
        end
        n_checks++;
        if (dest_ip_addr !== 32'hC0A80002) begin
            n_fail++;
            $display("FAIL t1_ip_hold got=%h exp=c0a80002", dest_ip_addr);
        end
        run_until_idle(10, ok);
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [5];
        int           exp_s [5];
        int           exp_p [5];
        logic [N-1:0] g_seen [$];
        int           gaps [$];
        logic [N-1:0] prev;
        int           gc;
        int           c;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_s = '{0, 1, 2, 3, 0};
        exp_p = '{0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < N; i++) begin src_nb[i] = 2; src_pk[i] = 1; end
        src_pk[0] = 2;
        drive_inputs();
        #1;
        prev = '0; gc = 0; c = 0;
        while (c < 1000 && (pending() || busy)) begin
            tick();
            c++;
            if (grant != '0 && prev == '0) g_seen.push_back(grant);
            if (busy && grant == '0) gc++;
            else if (gc > 0) begin gaps.push_back(gc); gc = 0; end
            prev = grant;
        end
        n_checks++;
        if (c >= 1000 || g_seen.size() != 5) begin
            n_fail++;
            $display("FAIL t2_grants got count=%0d cycles=%0d exp count=5", g_seen.size(), c);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (g_seen[k] !== exp_g[k]) begin
                    n_fail++;
                    $display("FAIL t2_grant%0d got=%b exp=%b", k, g_seen[k], exp_g[k]);
                end
            end
        end
        n_checks++;
        if (gaps.size() != 5) begin
            n_fail++;
            $display("FAIL t2_gap_count got=%0d exp=5", gaps.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (gaps[k] != GAP) begin
                    n_fail++;
                    $display("FAIL t2_gap%0d got=%0d exp=%0d", k, gaps[k], GAP);
                end
            end
        end
        n_checks++;
        if (log_data.size() != 10) begin
            n_fail++;
            $display("FAIL t2_beats got=%0d exp=10", log_data.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                n_checks++;
                if (log_data[k] !== beat_word(exp_s[k/2], exp_p[k/2], k % 2)) begin
                    n_fail++;
                    $display("FAIL t2_beat%0d got=%08h exp=%08h", k, log_data[k],
                             beat_word(exp_s[k/2], exp_p[k/2], k % 2));
                end
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        logic [31:0] hd;
        logic [3:0]  hk;
        bit          bad;
        bit          ok;
        int          g;
        do_reset();
        src_nb[0] = 4; src_pk[0] = 1;
        drive_inputs();
        g = 0;
        while (log_data.size() < 2 && g < 20) begin tick(); g++; end
        udp_to_app_ready = 1'b0;
        #1;
        hd = udp_from_app_data;
        hk = udp_from_app_keep;
        n_checks++;
        if (hd !== beat_word(0, 0, 2) || hk !== 4'hF) begin
            n_fail++;
            $display("FAIL t3_stall_beat got=%08h/%h exp=%08h/f", hd, hk, beat_word(0, 0, 2));
        end
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (udp_from_app_data !== hd || udp_from_app_keep !== hk ||
                req_ready[0] !== 1'b0 || udp_from_app_valid !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL t3_hold got data=%08h keep=%h ready0=%b exp data=%08h keep=%h ready0=0",
                     udp_from_app_data, udp_from_app_keep, req_ready[0], hd, hk);
        end
        udp_to_app_ready = 1'b1;
        #1;
        run_until_idle(200, ok);
        n_checks++;
        if (!ok || log_data.size() != 4) begin
            n_fail++;
            $display("FAIL t3_beats got count=%0d ok=%b exp count=4 ok=1", log_data.size(), ok);
        end else begin
            for (int b = 0; b < 4; b++) begin
                n_checks++;
                if (log_data[b] !== beat_word(0, 0, b)) begin
                    n_fail++;
                    $display("FAIL t3_beat%0d got=%08h exp=%08h", b, log_data[b], beat_word(0, 0, b));
                end
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_owner_stall();
        logic [31:0] exp_w [6];
        bit          bad;
        bit          ok;
        int          g;
        exp_w = '{beat_word(0, 0, 0), beat_word(0, 0, 1), beat_word(0, 0, 2), beat_word(0, 0, 3),
                  beat_word(2, 0, 0), beat_word(2, 0, 1)};
        do_reset();
        src_nb[0] = 4; src_pk[0] = 1;
        src_nb[2] = 2; src_pk[2] = 1;
        drive_inputs();
        g = 0;
        while (log_data.size() < 2 && g < 20) begin tick(); g++; end
        src_hold[0] = 1'b1;
        drive_inputs();
        #1;
        bad = 1'b0;
        repeat (3) begin
            if (grant !== 4'b0001 || req_ready[2] !== 1'b0 || udp_from_app_valid !== 1'b0) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL t4_stall got grant=%b ready2=%b valid=%b exp 0001/0/0",
                     grant, req_ready[2], udp_from_app_valid);
        end
        src_hold[0] = 1'b0;
        drive_inputs();
        #1;
        run_until_idle(400, ok);
        n_checks++;
        if (!ok || log_data.size() != 6) begin
            n_fail++;
            $display("FAIL t4_beats got count=%0d ok=%b exp count=6 ok=1", log_data.size(), ok);
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (log_data[k] !== exp_w[k]) begin
                    n_fail++;
                    $display("FAIL t4_beat%0d got=%08h exp=%08h", k, log_data[k], exp_w[k]);
                end
            end
        end
        $display("test_owner_stall done");
    endtask

    task automatic test_reset_mid();
        int g;
        do_reset();
        src_nb[0] = 4; src_pk[0] = 1;
        src_nb[1] = 4; src_pk[1] = 1;
        drive_inputs();
        g = 0;
        while (log_data.size() < 1 && g < 20) begin tick(); g++; end
        reset_32 = 1'b1;
        #1;
        n_checks++;
        if ({grant, busy, req_ready} !== '0 ||
            {udp_from_app_valid, udp_from_app_data, udp_from_app_keep, udp_from_app_last} !== 38'd0) begin
            n_fail++;
            $display("FAIL t5_abort got grant=%b busy=%b ready=%b valid=%b data=%08h keep=%h last=%b exp all 0",
                     grant, busy, req_ready, udp_from_app_valid, udp_from_app_data,
                     udp_from_app_keep, udp_from_app_last);
        end
        n_checks++;
        if ({data_from_app_length, dest_ip_addr, dest_port} !== 64'd0) begin
            n_fail++;
            $display("FAIL t5_latch got len=%h ip=%h port=%h exp 0",
                     data_from_app_length, dest_ip_addr, dest_port);
        end
        src_bt[0] = 0;
        log_data.delete();
        log_last.delete();
        drive_inputs();
        @(posedge clk_32);
        #1;
        reset_32 = 1'b0;
        #1;
        tick();
        n_checks++;
        if (grant !== 4'b0001 || udp_from_app_data !== beat_word(0, 0, 0)) begin
            n_fail++;
            $display("FAIL t5_regrant got grant=%b data=%08h exp 0001/%08h",
                     grant, udp_from_app_data, beat_word(0, 0, 0));
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_pkt_cnt();
        bit ok;
        bit bad;
        int c;
        do_reset();
        src_nb[1] = 1; src_pk[1] = 3;
        drive_inputs();
        #1;
        bad = 1'b0; c = 0;
        while (c < 600 && (pending() || busy)) begin
`ifndef ARB_PKT_CNT_EN
            if (pkt_cnt !== '0) bad = 1'b1;
`endif
            tick();
            c++;
        end
        n_checks++;
        if (c >= 600 || bad) begin
            n_fail++;
            $display("FAIL t6_run got cycles=%0d cnt_err=%b exp finish, cnt_err=0", c, bad);
        end
`ifdef ARB_PKT_CNT_EN
        n_checks++;
        if (pkt_cnt !== {16'd0, 16'd0, 16'd3, 16'd0}) begin
            n_fail++;
            $display("FAIL t6_cnt got=%h exp=%h", pkt_cnt, {16'd0, 16'd0, 16'd3, 16'd0});
        end
        force dut.gen_cnt[1].cnt_q = 16'hFFFF;
        @(posedge clk_32);
        #1;
        release dut.gen_cnt[1].cnt_q;
        src_pk[1] = 1;
        drive_inputs();
        #1;
        run_until_idle(200, ok);
        n_checks++;
        if (!ok || pkt_cnt !== 64'd0) begin
            n_fail++;
            $display("FAIL t6_wrap got=%h ok=%b exp=0 ok=1", pkt_cnt, ok);
        end
`else
        n_checks++;
        if (pkt_cnt !== '0) begin
            n_fail++;
            $display("FAIL t6_cnt_off got=%h exp=0", pkt_cnt);
        end
        ok = 1'b1;
`endif
        $display("test_pkt_cnt done ok=%b", ok);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_owner_stall();
        test_reset_mid();
        test_pkt_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
